// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: fetch FSM states, next-pc
// select codes, word width, NOP encoding and opcode/funct field positions.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SKID,
        ST_DRAIN
    } fetch_state_e;

    typedef enum logic [1:0] {
        NPC_PLUS4,
        NPC_BR,
        NPC_J,
        NPC_LATCH
    } npc_sel_e;

endpackage

// File: rtl/fetch_npc.sv
// Combinational next-pc select: sequential pc+4, branch target, jump target,
// or the redirect target latched while a request drains.
module fetch_npc
    import fetch_stage_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] j_target,
    input  logic [XLEN-1:0] latched_target,
    input  logic [1:0]      sel,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] npc
);

    // Wraps modulo 2^32 with no overflow indication.
    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        npc = pc_plus4;
        case (npc_sel_e'(sel))
            NPC_PLUS4: npc = pc_plus4;
            NPC_BR:    npc = br_target;
            NPC_J:     npc = j_target;
            NPC_LATCH: npc = latched_target;
            default:   npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order memory requests, buffers one
// instruction for decode plus one skid entry, and handles branch/jump redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP      = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            pcsrc,
    input  logic            jump,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] j_target,
    input  logic            id_stall,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pcplus4,
    output logic [5:0]      op,
    output logic [5:0]      funct
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pcplus4_q;
    logic            instr_valid_q;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pcplus4;
    logic [XLEN-1:0] tgt_q;

    logic            redirect;
    logic            accept;
    logic            consume;
    logic            out_free;
    npc_sel_e        npc_sel;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc_plus4;

    assign redirect = pcsrc | jump;
    assign imem_req = (state == ST_FETCH) || (state == ST_DRAIN);
    assign accept   = imem_req & imem_ready;
    assign consume  = instr_valid_q & ~id_stall;
    assign out_free = ~instr_valid_q | consume;

    // Jump outranks branch; with no redirect, a draining request resumes at the latched target.
    always_comb begin
        if (jump)
            npc_sel = NPC_J;
        else if (pcsrc)
            npc_sel = NPC_BR;
        else if (state == ST_DRAIN)
            npc_sel = NPC_LATCH;
        else
            npc_sel = NPC_PLUS4;
    end

    fetch_npc u_npc (
        .pc             (pc),
        .br_target      (br_target),
        .j_target       (j_target),
        .latched_target (tgt_q),
        .sel            (npc_sel),
        .pc_plus4       (pc_plus4),
        .npc            (npc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            instr_q       <= NOP;
            pcplus4_q     <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            if (consume) begin
                instr_valid_q <= 1'b0;
                instr_q       <= NOP;
            end

            case (state)
                ST_IDLE: begin
                    if (redirect)
                        pc <= npc;
                    state <= ST_FETCH;
                end

                ST_FETCH: begin
                    if (redirect) begin
                        // An unanswered request cannot be withdrawn: wait it out in DRAIN.
                        if (accept) begin
                            pc <= npc;
                        end else begin
                            tgt_q <= npc;
                            state <= ST_DRAIN;
                        end
                    end else if (accept) begin
                        pc <= npc;
                        if (out_free) begin
                            instr_q       <= imem_rdata;
                            pcplus4_q     <= pc_plus4;
                            instr_valid_q <= 1'b1;
                        end else begin
                            skid_instr   <= imem_rdata;
                            skid_pcplus4 <= pc_plus4;
                            state        <= ST_SKID;
                        end
                    end
                end

                ST_SKID: begin
                    if (redirect) begin
                        pc    <= npc;
                        state <= ST_FETCH;
                    end else if (!id_stall) begin
                        instr_q       <= skid_instr;
                        pcplus4_q     <= skid_pcplus4;
                        instr_valid_q <= 1'b1;
                        state         <= ST_FETCH;
                    end
                end

                ST_DRAIN: begin
                    if (accept) begin
                        pc    <= npc;
                        state <= ST_FETCH;
                    end else if (redirect) begin
                        tgt_q <= npc;
                    end
                end

                default: state <= ST_IDLE;
            endcase

            // A redirect kills whatever decode was holding, stalled or not.
            if (redirect) begin
                instr_valid_q <= 1'b0;
                instr_q       <= NOP;
            end
        end
    end

    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pcplus4     = pcplus4_q;
    assign op          = instr_q[OP_MSB:OP_LSB];
    assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed cycle-by-cycle bench for fetch_stage: a table of per-cycle inputs and
// expected outputs, followed by a reset-during-drain sequence.
module tb_fetch_stage;

    localparam logic [31:0] TB_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        pcsrc;
    logic        jump;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        id_stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pcplus4;
    logic [5:0]  op;
    logic [5:0]  funct;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP      (TB_NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .br_target   (br_target),
        .j_target    (j_target),
        .id_stall    (id_stall),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pcplus4     (pcplus4),
        .op          (op),
        .funct       (funct)
    );

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        pcsrc;
        logic [31:0] br;
        logic        jump;
        logic [31:0] jt;
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_vld;
        logic [31:0] exp_ia;
        logic        chk_pp4;
        logic [31:0] exp_pp4;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    // Memory contents: op=0x23, low address bits in the rest, so funct = addr[5:0].
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {6'h23, 2'b00, a[23:0]};
    endfunction

    function automatic vec_t mk(
        input logic r, input logic rdy, input logic ps, input logic [31:0] br,
        input logic j, input logic [31:0] jt, input logic st,
        input logic ereq, input logic [31:0] eaddr, input logic evld,
        input logic [31:0] eia, input logic cpp4, input logic [31:0] epp4);
        vec_t v;
        v.rst_n = r;    v.ready = rdy;  v.pcsrc = ps;   v.br = br;
        v.jump = j;     v.jt = jt;      v.stall = st;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_vld = evld;
        v.exp_ia = eia; v.chk_pp4 = cpp4; v.exp_pp4 = epp4;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    initial begin
        logic [31:0] ei;
        int lat;

        //              rst rdy ps br        j  jt            st | req addr          vld ia            cp pp4
        tbl[0]  = mk(1, 1, 0, 0,       0, 0,            0,   0, 32'h0,        0, 0,            1, 32'h0);
        tbl[1]  = mk(1, 1, 0, 0,       0, 0,            0,   1, 32'h0,        0, 0,            0, 0);
        tbl[2]  = mk(1, 1, 0, 0,       0, 0,            0,   1, 32'h4,        1, 32'h0,        1, 32'h4);
        tbl[3]  = mk(1, 1, 0, 0,       0, 0,            0,   1, 32'h8,        1, 32'h4,        1, 32'h8);
        tbl[4]  = mk(1, 1, 0, 0,       0, 0,            1,   1, 32'hC,        1, 32'h8,        1, 32'hC);
        tbl[5]  = mk(1, 1, 0, 0,       0, 0,            1,   0, 32'h10,       1, 32'h8,        1, 32'hC);
        tbl[6]  = mk(1, 1, 0, 0,       0, 0,            1,   0, 32'h10,       1, 32'h8,        1, 32'hC);
        tbl[7]  = mk(1, 1, 0, 0,       0, 0,            0,   0, 32'h10,       1, 32'h8,        1, 32'hC);
        tbl[8]  = mk(1, 1, 0, 0,       0, 0,            0,   1, 32'h10,       1, 32'hC,        1, 32'h10);
        tbl[9]  = mk(1, 0, 0, 0,       0, 0,            0,   1, 32'h14,       1, 32'h10,       1, 32'h14);
        tbl[10] = mk(1, 1, 1, 32'h10,  0, 0,            0,   1, 32'h14,       0, 0,            0, 0);
        tbl[11] = mk(1, 0, 0, 0,       1, 32'h400,      0,   1, 32'h10,       0, 0,            0, 0);
        tbl[12] = mk(1, 0, 0, 0,       0, 0,            0,   1, 32'h10,       0, 0,            0, 0);
        tbl[13] = mk(1, 1, 0, 0,       0, 0,            0,   1, 32'h10,       0, 0,            0, 0);
        tbl[14] = mk(1, 0, 0, 0,       0, 0,            0,   1, 32'h400,      0, 0,            0, 0);
        tbl[15] = mk(1, 1, 0, 0,       0, 0,            0,   1, 32'h400,      0, 0,            0, 0);
        tbl[16] = mk(1, 1, 1, 32'h100, 1, 32'h200,      0,   1, 32'h404,      1, 32'h400,      1, 32'h404);
        tbl[17] = mk(1, 0, 0, 0,       1, 32'h300,      0,   1, 32'h200,      0, 0,            0, 0);
        tbl[18] = mk(1, 0, 1, 32'h500, 0, 0,            0,   1, 32'h200,      0, 0,            0, 0);
        tbl[19] = mk(1, 1, 0, 0,       1, 32'h600,      0,   1, 32'h200,      0, 0,            0, 0);
        tbl[20] = mk(1, 1, 0, 0,       1, 32'hFFFF_FFFC, 0,  1, 32'h600,      0, 0,            0, 0);
        tbl[21] = mk(1, 1, 0, 0,       0, 0,            0,   1, 32'hFFFF_FFFC, 0, 0,           0, 0);
        tbl[22] = mk(1, 1, 0, 0,       0, 0,            1,   1, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'h0);
        tbl[23] = mk(1, 0, 1, 32'h40,  0, 0,            1,   0, 32'h4,        1, 32'hFFFF_FFFC, 1, 32'h0);
        tbl[24] = mk(1, 0, 0, 0,       1, 32'h80,       0,   1, 32'h40,       0, 0,            0, 0);

        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        pcsrc = 1'b0; jump = 1'b0; br_target = '0; j_target = '0; id_stall = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n      = tbl[i].rst_n;
            imem_ready = tbl[i].ready;
            imem_rdata = tbl[i].ready ? mem_word(tbl[i].exp_addr) : 32'hDEAD_BEEF;
            pcsrc      = tbl[i].pcsrc;
            br_target  = tbl[i].br;
            jump       = tbl[i].jump;
            j_target   = tbl[i].jt;
            id_stall   = tbl[i].stall;
            #1;
            ei = tbl[i].exp_vld ? mem_word(tbl[i].exp_ia) : TB_NOP;
            chk($sformatf("v%0d.req", i),   {31'b0, imem_req},    {31'b0, tbl[i].exp_req});
            chk($sformatf("v%0d.addr", i),  imem_addr,            tbl[i].exp_addr);
            chk($sformatf("v%0d.vld", i),   {31'b0, instr_valid}, {31'b0, tbl[i].exp_vld});
            chk($sformatf("v%0d.instr", i), instr,                ei);
            chk($sformatf("v%0d.op", i),    {26'b0, op},          {26'b0, ei[31:26]});
            chk($sformatf("v%0d.funct", i), {26'b0, funct},       {26'b0, ei[5:0]});
            if (tbl[i].chk_pp4)
                chk($sformatf("v%0d.pcplus4", i), pcplus4, tbl[i].exp_pp4);
        end

        // Reset asserted while draining a request to 0x40.
        @(negedge clk);
        pcsrc = 1'b0; jump = 1'b0; id_stall = 1'b0; imem_ready = 1'b0;
        #1;
        chk("drain.req",  {31'b0, imem_req}, 32'd1);
        chk("drain.addr", imem_addr, 32'h40);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst.req",     {31'b0, imem_req},    32'd0);
        chk("rst.addr",    imem_addr,            32'h0);
        chk("rst.vld",     {31'b0, instr_valid}, 32'd0);
        chk("rst.instr",   instr,                TB_NOP);
        chk("rst.pcplus4", pcplus4,              32'h0);
        rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = mem_word(32'h0);

        lat = -1;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            #1;
            if (instr_valid) lat = k;
        end
        chk("rst_to_valid_cycles", lat, 32'd2);
        chk("post_rst.instr",   instr,   mem_word(32'h0));
        chk("post_rst.pcplus4", pcplus4, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter NOP, default 32'h0000_0000, value driven on instr while instr_valid=0.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 imem_req  out  1  instruction-memory request, held until imem_ready.
REQ-006 imem_addr  out  32  fetch address, stable while imem_req=1.
REQ-007 imem_ready  in  1  imem_rdata valid for imem_addr this cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 pcsrc  in  1  taken-branch redirect from decode/control.
REQ-010 jump  in  1  jump redirect from decode/control.
REQ-011 br_target  in  32  branch target.
REQ-012 j_target  in  32  jump target.
REQ-013 id_stall  in  1  decode cannot accept; instr held.
REQ-014 instr  out  32  registered instruction for decode.
REQ-015 instr_valid  out  1  instr holds a live instruction.
REQ-016 pcplus4  out  32  address of instr plus 4.
REQ-017 op  out  6  instr[31:26], to controller.
REQ-018 funct  out  6  instr[5:0], to controller.

Function
REQ-019 States: IDLE, FETCH, SKID, DRAIN; registers pc, out buffer (instr, pcplus4, instr_valid), one skid entry, latched redirect target.
REQ-020 Accept = imem_req & imem_ready; consume = instr_valid & ~id_stall; redirect = pcsrc | jump; target = jump ? j_target : br_target (jump priority).
REQ-021 IDLE: imem_req=0; next state FETCH, no other condition.
REQ-022 FETCH: imem_req=1, imem_addr=pc.
REQ-023 FETCH, accept, no redirect, out buffer empty or consumed: load out buffer with imem_rdata, pc+4; pc<=pc+4; stay FETCH (back-to-back, one instr/cycle at zero-wait memory).
REQ-024 FETCH, accept, no redirect, out buffer full and id_stall=1: load skid; pc<=pc+4; go SKID.
REQ-025 SKID: imem_req=0; on ~id_stall move skid into out buffer, go FETCH.
REQ-026 Redirect in any state: out buffer and skid flushed (instr_valid=0 next cycle); redirect wins over id_stall and over accept.
REQ-027 Redirect in IDLE, SKID, or FETCH with accept: accepted data dropped; pc<=target; next state FETCH.
REQ-028 Redirect in FETCH without accept: request is non-retractable; latch target; go DRAIN.
REQ-029 DRAIN: imem_req=1, imem_addr unchanged, instr_valid=0; further redirect overwrites latched target; on accept, data discarded, pc<=latched target, go FETCH.
REQ-030 Redirect in DRAIN coincident with accept: pc<=new target, data discarded, go FETCH.
REQ-031 instr=NOP whenever instr_valid=0; op/funct combinational from instr.
REQ-032 pc arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0, no flag.
REQ-033 Latency: imem_ready in cycle N with free buffer -> instr_valid=1 in N+1.

Reset
REQ-034 rst_n=0 at an edge: state IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=NOP, pcplus4=0, skid empty.
REQ-035 Reset mid-operation abandons any outstanding request without waiting for imem_ready; memory-side cleanup is the memory's responsibility.
REQ-036 First request at RESET_PC issued the second cycle after rst_n rises (IDLE, then FETCH).

Structure
REQ-037 Shared package holds the fetch-state enum, XLEN=32, NOP encoding, and opcode/funct field bit ranges used by op/funct extraction and the controller.
REQ-038 One sub-module, fetch_npc: combinational next-pc select (pc+4 / br_target / j_target / latched target).

Verification
REQ-039 Reset release, zero-wait memory (imem_ready=1) -> imem_addr 0,4,8 in consecutive cycles; instr_valid=1 from third cycle after rst_n rise.
REQ-040 id_stall=1 for 3 cycles with instr at 0x8 valid, ready continuous -> 0xC captured in skid, imem_req=0, instr at 0x8 held; after release instr sequence 0x8,0xC,0x10 without loss.
REQ-041 Request at 0x10 outstanding (ready=0), jump=1 j_target=0x400 -> DRAIN, addr held 0x10; on ready data dropped, next addr 0x400, instr_valid=0 until 0x400 data.
REQ-042 pcsrc=1 br_target=0x100 and jump=1 j_target=0x200 same cycle -> next fetch address 0x200.
REQ-043 rst_n=0 during DRAIN -> next cycle IDLE, pc=RESET_PC, instr_valid=0, instr=NOP.
REQ-044 pc=0xFFFF_FFFC, accepted -> next imem_addr 0x0, pcplus4=0x0.
